// File: rtl/i2c_drain_pkg.sv
// Shared definitions for the I2C slave-FIFO drain controller: FSM encoding,
// frame header constants and the header byte builder.
package i2c_drain_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR0 = 3'd1,
        ST_HDR1 = 3'd2,
        ST_READ = 3'd3,
        ST_WAIT = 3'd4,
        ST_SEND = 3'd5
    } state_t;

    localparam logic [3:0] SYNC_NIBBLE = 4'hA;
    localparam logic       HDR_BYTE0   = 1'b0;
    localparam logic       HDR_BYTE1   = 1'b1;
    localparam logic [6:0] MAX_CNT     = 7'd64;

    // Byte1 carries the full 7-bit count so a full FIFO (64) reads as 8'h40.
    function automatic logic [7:0] hdr_byte(input logic       idx,
                                            input logic [3:0] chan,
                                            input logic [6:0] cnt);
        logic [7:0] b;
        if (idx == HDR_BYTE0) begin
            b = {SYNC_NIBBLE, chan};
        end else begin
            b = {1'b0, cnt};
        end
        return b;
    endfunction

endpackage

// File: rtl/prio_enc_lsb.sv
// Lowest-index priority encoder: returns the index and the one-hot of the
// least significant set bit of an N-bit request vector (N <= 16).
module prio_enc_lsb #(
    parameter int N = 12
) (
    input  logic [N-1:0] i_vec,
    output logic [3:0]   o_idx,
    output logic [N-1:0] o_onehot
);

    logic [N-1:0] w_onehot;

    // Isolate the lowest set bit with the two's-complement trick.
    assign w_onehot = i_vec & (~i_vec + N'(1));
    assign o_onehot = w_onehot;

    // Fold the one-hot back into a binary index.
    always_comb begin
        o_idx = 4'd0;
        for (int i = 0; i < N; i++) begin
            o_idx = o_idx | ({4{w_onehot[i]}} & 4'(i));
        end
    end

endmodule

// File: rtl/i2c_slave_drain.sv
// Drains one completed message at a time from the shared slave-capture FIFO
// and forwards it as a {sync|chan, count, payload...} byte stream.
module i2c_slave_drain
    import i2c_drain_pkg::*;
#(
    parameter int N = 12
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic [N-1:0] have_msg_bus,
    input  logic [N-1:0] sstat_bus,
    input  logic [7:0]   len,
    input  logic [7:0]   s_dout,
    output logic [N-1:0] s_rdreq_bus,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         tx_last,
    output logic         busy
);

    state_t       r_state, w_state_nxt;
    logic [6:0]   r_cnt, w_cnt_nxt;
    logic [3:0]   r_chan, w_chan_nxt;
    logic [N-1:0] r_chan_oh, w_chan_oh_nxt;
    logic [7:0]   r_tx_data, w_tx_data_nxt;
    logic         r_tx_valid, w_tx_valid_nxt;
    logic         r_tx_last, w_tx_last_nxt;
    logic [N-1:0] r_rdreq, w_rdreq_nxt;
    logic         r_busy;

    logic [3:0]   w_enc_idx;
    logic [N-1:0] w_enc_oh;
    logic         w_start;
    logic         w_hs;
    logic [6:0]   w_snap_cnt;
    logic         w_len_unused;

    prio_enc_lsb #(.N(N)) u_prio (
        .i_vec    (have_msg_bus),
        .o_idx    (w_enc_idx),
        .o_onehot (w_enc_oh)
    );

    assign w_start      = (|have_msg_bus) & ~(|sstat_bus);
    assign w_hs         = r_tx_valid & tx_ready;
    // An empty fill level with a message pending means the FIFO wrapped full.
    assign w_snap_cnt   = (len[5:0] == 6'd0) ? MAX_CNT : {1'b0, len[5:0]};
    assign w_len_unused = ^len[7:6];

    // Next-state and next-output logic; outputs hold unless a transition updates them.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_chan_nxt     = r_chan;
        w_chan_oh_nxt  = r_chan_oh;
        w_tx_data_nxt  = r_tx_data;
        w_tx_valid_nxt = r_tx_valid;
        w_tx_last_nxt  = r_tx_last;
        w_rdreq_nxt    = {N{1'b0}};
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt    = ST_HDR0;
                    w_cnt_nxt      = w_snap_cnt;
                    w_chan_nxt     = w_enc_idx;
                    w_chan_oh_nxt  = w_enc_oh;
                    w_tx_data_nxt  = hdr_byte(HDR_BYTE0, w_enc_idx, w_snap_cnt);
                    w_tx_valid_nxt = 1'b1;
                    w_tx_last_nxt  = 1'b0;
                end else begin
                    w_tx_valid_nxt = 1'b0;
                    w_tx_last_nxt  = 1'b0;
                end
            end
            ST_HDR0: begin
                if (w_hs) begin
                    w_state_nxt   = ST_HDR1;
                    w_tx_data_nxt = hdr_byte(HDR_BYTE1, r_chan, r_cnt);
                end else begin
                    w_state_nxt   = ST_HDR0;
                end
            end
            ST_HDR1: begin
                if (w_hs) begin
                    w_state_nxt    = ST_READ;
                    w_tx_valid_nxt = 1'b0;
                    w_rdreq_nxt    = r_chan_oh;
                end else begin
                    w_state_nxt    = ST_HDR1;
                end
            end
            ST_READ: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                w_state_nxt    = ST_SEND;
                w_tx_data_nxt  = s_dout;
                w_tx_valid_nxt = 1'b1;
                w_tx_last_nxt  = (r_cnt == 7'd1);
            end
            ST_SEND: begin
                if (w_hs) begin
                    w_cnt_nxt      = r_cnt - 7'd1;
                    w_tx_valid_nxt = 1'b0;
                    w_tx_last_nxt  = 1'b0;
                    if (r_cnt != 7'd1) begin
                        w_state_nxt = ST_READ;
                        w_rdreq_nxt = r_chan_oh;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_SEND;
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_tx_valid_nxt = 1'b0;
                w_tx_last_nxt  = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame context and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt      <= 7'd0;
            r_chan     <= 4'd0;
            r_chan_oh  <= {N{1'b0}};
            r_tx_data  <= 8'd0;
            r_tx_valid <= 1'b0;
            r_tx_last  <= 1'b0;
            r_rdreq    <= {N{1'b0}};
            r_busy     <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_chan     <= w_chan_nxt;
            r_chan_oh  <= w_chan_oh_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_valid <= w_tx_valid_nxt;
            r_tx_last  <= w_tx_last_nxt;
            r_rdreq    <= w_rdreq_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
        end
    end

    assign s_rdreq_bus = r_rdreq;
    assign tx_data     = r_tx_data;
    assign tx_valid    = r_tx_valid;
    assign tx_last     = r_tx_last;
    assign busy        = r_busy;

endmodule

// File: tb/tb_i2c_slave_drain.sv
// Self-checking bench: per-channel FIFO model drives the DUT, frames are
// predicted from the queued contents and compared against the captured stream.
module tb_i2c_slave_drain;

    localparam int N = 12;

    logic         clk = 1'b0;
    logic         n_rst;
    logic [N-1:0] have_msg_bus;
    logic [N-1:0] sstat_bus;
    logic [7:0]   len;
    logic [7:0]   s_dout;
    logic [N-1:0] s_rdreq_bus;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         tx_last;
    logic         busy;

    always #5 clk = ~clk;

    i2c_slave_drain #(.N(N)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .have_msg_bus (have_msg_bus),
        .sstat_bus    (sstat_bus),
        .len          (len),
        .s_dout       (s_dout),
        .s_rdreq_bus  (s_rdreq_bus),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_last      (tx_last),
        .busy         (busy)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] fifo_q [N][$];
    logic [8:0] rx_q [$];
    logic [8:0] exp_q [$];
    int         strobe_cnt [N];
    int         exp_strobes [N];
    int         bad_strobe;
    int         stall_err;
    int         busy_cycles;
    int         ready_mode = 0;

    logic [N-1:0] prev_rd;
    logic [7:0]   pend;
    logic         pend_v = 1'b0;
    logic [7:0]   stall_data;
    logic         stall_v = 1'b0;

    typedef struct {
        logic [N-1:0] mask;
        int           cnt;
        int           mode;
        logic [7:0]   hdr0;
        logic [7:0]   hdr1;
        int           cycles;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        rx_q.delete();
        exp_q.delete();
        for (int c = 0; c < N; c++) begin
            strobe_cnt[c]  = 0;
            exp_strobes[c] = 0;
        end
        bad_strobe  = 0;
        stall_err   = 0;
        busy_cycles = 0;
    endtask

    task automatic load(input logic [N-1:0] mask, input int cnt);
        for (int c = 0; c < N; c++) begin
            if (mask[c]) begin
                for (int j = 0; j < cnt; j++) fifo_q[c].push_back(8'($urandom));
            end
        end
    endtask

    // Reference: each non-empty channel, lowest first, yields one whole frame.
    task automatic build_exp();
        exp_q.delete();
        for (int c = 0; c < N; c++) begin
            int sz;
            sz = fifo_q[c].size();
            exp_strobes[c] = sz;
            if (sz > 0) begin
                exp_q.push_back({1'b0, 4'hA, 4'(c)});
                exp_q.push_back({1'b0, 8'(sz)});
                for (int j = 0; j < sz; j++) exp_q.push_back({(j == sz - 1), fifo_q[c][j]});
            end
        end
    endtask

    task automatic finish_frame(input string name, input int exp_cycles);
        int t;
        t = 0;
        while (!(rx_q.size() >= exp_q.size() && !busy) && t < 3000) begin
            @(negedge clk); #1;
            t++;
        end
        if (t >= 3000) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d bytes expected %0d", name, rx_q.size(), exp_q.size());
        end
        repeat (3) @(negedge clk);
        #1;
        chk({name, "_nbytes"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            chk($sformatf("%s_byte%0d", name, i), {23'd0, rx_q[i]}, {23'd0, exp_q[i]});
        for (int c = 0; c < N; c++)
            chk($sformatf("%s_strobes_ch%0d", name, c), strobe_cnt[c], exp_strobes[c]);
        chk({name, "_strobe_shape"}, bad_strobe, 0);
        chk({name, "_stall_stable"}, stall_err, 0);
        if (exp_cycles > 0) chk({name, "_cycles"}, busy_cycles, exp_cycles);
    endtask

    // FIFO model, tx_ready driver and stream capture, all on the falling edge.
    initial begin
        forever begin
            logic [N-1:0] hm;
            int lsz;
            @(negedge clk);
            if (!n_rst) begin
                pend_v  = 1'b0;
                prev_rd = {N{1'b0}};
                stall_v = 1'b0;
                s_dout  = 8'($urandom);
            end else begin
                if (pend_v) begin
                    s_dout = pend;
                    pend_v = 1'b0;
                end else begin
                    s_dout = 8'($urandom);
                end
                if (s_rdreq_bus != {N{1'b0}}) begin
                    if ($countones(s_rdreq_bus) != 1 || prev_rd != {N{1'b0}} || tx_valid) bad_strobe++;
                    for (int c = 0; c < N; c++) begin
                        if (s_rdreq_bus[c]) begin
                            strobe_cnt[c]++;
                            if (fifo_q[c].size() > 0) begin
                                pend   = fifo_q[c].pop_front();
                                pend_v = 1'b1;
                            end
                        end
                    end
                end
                prev_rd = s_rdreq_bus;
                if (stall_v && (!tx_valid || tx_data != stall_data)) stall_err++;
                if (busy) busy_cycles++;
            end
            case (ready_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = 1'($urandom_range(0, 1));
                default: tx_ready = 1'b0;
            endcase
            if (n_rst && tx_valid && tx_ready) rx_q.push_back({tx_last, tx_data});
            stall_v    = n_rst && tx_valid && !tx_ready;
            stall_data = tx_data;
            lsz = -1;
            for (int c = 0; c < N; c++) begin
                hm[c] = (fifo_q[c].size() != 0);
                if (lsz < 0 && fifo_q[c].size() != 0) lsz = fifo_q[c].size();
            end
            have_msg_bus = hm;
            len = (lsz < 0) ? {2'($urandom), 6'd0} : {2'($urandom), 6'(lsz)};
        end
    end

    initial begin
        int t;
        vecs[0] = '{12'h020, 3,  0, 8'hA5, 8'h03, 11};
        vecs[1] = '{12'h001, 64, 0, 8'hA0, 8'h40, 194};
        vecs[2] = '{12'h200, 10, 1, 8'hA9, 8'h0A, 0};
        vecs[3] = '{12'h090, 2,  0, 8'hA4, 8'h02, 16};
        vecs[4] = '{12'h800, 1,  0, 8'hAB, 8'h01, 5};
        vecs[5] = '{12'h008, 7,  1, 8'hA3, 8'h07, 0};

        n_rst        = 1'b0;
        have_msg_bus = {N{1'b0}};
        sstat_bus    = {N{1'b0}};
        len          = 8'd0;
        s_dout       = 8'd0;
        tx_ready     = 1'b0;
        clear_stats();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_tx_data", tx_data, 8'd0);
        chk("rst_tx_last", tx_last, 1'b0);
        chk("rst_rdreq", s_rdreq_bus, {N{1'b0}});
        chk("rst_busy", busy, 1'b0);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            clear_stats();
            ready_mode = vecs[v].mode;
            load(vecs[v].mask, vecs[v].cnt);
            build_exp();
            finish_frame($sformatf("vec%0d", v), vecs[v].cycles);
            if (rx_q.size() >= 2) begin
                chk($sformatf("vec%0d_hdr0", v), rx_q[0][7:0], vecs[v].hdr0);
                chk($sformatf("vec%0d_hdr1", v), rx_q[1][7:0], vecs[v].hdr1);
            end else begin
                chk($sformatf("vec%0d_hdr_present", v), rx_q.size(), 2);
            end
        end

        // Message held off while another channel is mid-transaction.
        clear_stats();
        ready_mode = 0;
        sstat_bus  = 12'h004;
        load(12'h020, 2);
        build_exp();
        repeat (20) @(negedge clk);
        #1;
        chk("sstat_hold_busy", busy, 1'b0);
        chk("sstat_hold_valid", tx_valid, 1'b0);
        chk("sstat_hold_bytes", rx_q.size(), 0);
        sstat_bus = {N{1'b0}};
        @(negedge clk);
        #1;
        chk("sstat_start_valid", tx_valid, 1'b1);
        chk("sstat_start_hdr0", tx_data, 8'hA5);
        finish_frame("sstat", 8);

        // Reset in the middle of the payload; the remainder forms a fresh frame.
        clear_stats();
        ready_mode = 0;
        load(12'h004, 8);
        build_exp();
        t = 0;
        while (strobe_cnt[2] < 3 && t < 200) begin
            @(negedge clk); #1;
            t++;
        end
        chk("midrst_reached", (strobe_cnt[2] >= 3), 1'b1);
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        chk("midrst_tx_valid", tx_valid, 1'b0);
        chk("midrst_tx_data", tx_data, 8'd0);
        chk("midrst_tx_last", tx_last, 1'b0);
        chk("midrst_rdreq", s_rdreq_bus, {N{1'b0}});
        chk("midrst_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        clear_stats();
        build_exp();
        chk("midrst_remaining", exp_strobes[2], 5);
        n_rst = 1'b1;
        finish_frame("midrst", 17);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
